// File: rtl/chiplib_pri_queue_push_arb.sv
// chiplib_pri_queue_push_arb
//
// Shares the single push port of a chiplib priority queue among NumReq
// producers. The most urgent request wins: the smallest pri value, with ties
// broken round-robin. A per-requester age counter counts denied arbitrations.
// Once a valid requester's counter reaches AgeLimit, the starving requesters
// take precedence over priority. This bounds how long any requester can wait.
// One registered output stage gives 1-cycle latency and 1 push per cycle.

module chiplib_pri_queue_push_arb #(
  parameter int NumReq        = 4,
  parameter int DataWidth     = 64,
  parameter int PriorityWidth = 16,
  parameter int AgeLimit      = 8,
  localparam int IdxWidth     = $clog2(NumReq)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NumReq-1:0]               req_valid,
  output logic [NumReq-1:0]               req_ready,
  input  logic [NumReq*DataWidth-1:0]     req_data,
  input  logic [NumReq*PriorityWidth-1:0] req_pri,
  output logic                            queue_push_valid,
  output logic [DataWidth-1:0]            queue_push_data,
  output logic [PriorityWidth-1:0]        queue_push_pri,
  output logic [IdxWidth-1:0]             queue_push_src,
  input  logic                            full
);

  localparam int                     AgeWidth = $clog2(AgeLimit + 1);
  localparam logic [AgeWidth-1:0]    AgeMax   = AgeWidth'(AgeLimit);
  localparam logic [IdxWidth:0]      NumReqW  = (IdxWidth + 1)'(NumReq);

  // Unpacked views of the flat request buses
  logic [DataWidth-1:0]     data_arr [NumReq];
  logic [PriorityWidth-1:0] pri_arr  [NumReq];

  // Arbitration state
  logic [AgeWidth-1:0]      age_q    [NumReq];
  logic [IdxWidth-1:0]      rr_ptr_q;

  // Output stage
  logic                     out_valid_q;
  logic [DataWidth-1:0]     out_data_q;
  logic [PriorityWidth-1:0] out_pri_q;
  logic [IdxWidth-1:0]      out_src_q;

  // Combinational arbitration signals
  logic                     drain;
  logic                     can_load;
  logic                     any_valid;
  logic                     grant;
  logic [NumReq-1:0]        starving;
  logic                     any_starving;
  logic [PriorityWidth-1:0] min_pri;
  logic [NumReq-1:0]        cand;
  logic [2*NumReq-1:0]      cand_dbl;
  logic [IdxWidth-1:0]      offset;
  logic [IdxWidth:0]        win_sum;
  logic [IdxWidth-1:0]      winner;
  logic [IdxWidth:0]        next_sum;
  logic [IdxWidth-1:0]      rr_next;

  // Slice the packed request buses into per-requester fields
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      data_arr[i] = req_data[i*DataWidth +: DataWidth];
      pri_arr[i]  = req_pri[i*PriorityWidth +: PriorityWidth];
    end
  end

  // Output-stage flow control: the held entry leaves when the queue is not full
  assign drain     = out_valid_q & ~full;
  assign can_load  = ~out_valid_q | drain;
  assign any_valid = |req_valid;
  // Reset blocks acceptance so nothing is taken that the reset would then drop
  assign grant     = any_valid & can_load & ~rst;

  // Find the most urgent priority among valid requesters, and flag starving ones
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // update; a path that leaves a variable unassigned would infer a latch.
    min_pri  = '1;
    starving = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (req_valid[i] && (pri_arr[i] < min_pri)) begin
        min_pri = pri_arr[i];
      end
      starving[i] = req_valid[i] && (age_q[i] == AgeMax);
    end
  end

  assign any_starving = |starving;

  // Candidate set: starving requesters override priority, else all min-pri requesters
  always_comb begin
    cand = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand[i] = any_starving ? starving[i]
                             : (req_valid[i] && (pri_arr[i] == min_pri));
    end
  end

  // Round-robin pick: the first candidate at or after rr_ptr, wrapping at NumReq-1
  always_comb begin
    cand_dbl = {cand, cand} >> rr_ptr_q;
    offset   = '0;
    // Scan downwards so the lowest set offset is the one that remains
    for (int k = NumReq - 1; k >= 0; k--) begin
      if (cand_dbl[k]) begin
        offset = IdxWidth'(k);
      end
    end
    win_sum = {1'b0, rr_ptr_q} + {1'b0, offset};
    winner  = (win_sum >= NumReqW) ? IdxWidth'(win_sum - NumReqW)
                                   : win_sum[IdxWidth-1:0];
    next_sum = {1'b0, winner} + (IdxWidth + 1)'(1);
    rr_next  = (next_sum == NumReqW) ? '0 : next_sum[IdxWidth-1:0];
  end

  // One-hot accept for the winner whenever the output stage can take a new entry
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NumReq; i++) begin
      req_ready[i] = grant && (winner == IdxWidth'(i));
    end
  end

  // Output valid and round-robin pointer
  always_ff @(posedge clk) begin
    // NOTE: registers are written with non-blocking assignments so that
    // every flop samples the values from before the edge, whatever the block order.
    if (rst) begin
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else if (grant) begin
      out_valid_q <= 1'b1;
      rr_ptr_q    <= rr_next;
    end else if (drain) begin
      out_valid_q <= 1'b0;
    end
  end

  // Capture the winning payload and its priority and source index
  always_ff @(posedge clk) begin
    // NOTE: the payload registers have no reset. They are only meaningful
    // while out_valid_q is set, so a reset here would add fanout with no
    // functional gain.
    if (grant) begin
      out_data_q <= data_arr[winner];
      out_pri_q  <= pri_arr[winner];
      out_src_q  <= winner;
    end
  end

  // Age counters: count lost arbitrations, saturate at AgeLimit, clear on win or idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumReq; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        if (!req_valid[i]) begin
          age_q[i] <= '0;
        end else if (grant) begin
          if (winner == IdxWidth'(i)) begin
            age_q[i] <= '0;
          end else if (age_q[i] != AgeMax) begin
            age_q[i] <= age_q[i] + 1'b1;
          end
        end
      end
    end
  end

  assign queue_push_valid = out_valid_q;
  assign queue_push_data  = out_data_q;
  assign queue_push_pri   = out_pri_q;
  assign queue_push_src   = out_src_q;

endmodule

// File: tb/tb_chiplib_pri_queue_push_arb.sv
// Self-checking bench for chiplib_pri_queue_push_arb.
// Directed vector tables cover the reset state, priority ties, aging, and
// back-pressure. Hand-written sequences cover a reset taken mid-operation and
// a single active requester. A randomized phase compares the DUT against a
// reference arbiter and a push-order scoreboard.

module tb_chiplib_pri_queue_push_arb;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int PW = 16;

  typedef struct {
    logic [N-1:0] valid;
    logic         full;
    logic [N-1:0] exp_ready;
    logic         exp_pv;
    int           exp_src;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [PW-1:0] pri;
    int            src;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            rst_a;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N*PW-1:0] req_pri;
  logic            full;

  logic [N-1:0]    ready_m,  ready_a;
  logic            pv_m,     pv_a;
  logic [DW-1:0]   pdata_m,  pdata_a;
  logic [PW-1:0]   ppri_m,   ppri_a;
  logic [1:0]      psrc_m,   psrc_a;

  // Select which instance the directed checks observe
  logic            sel_a = 1'b0;
  logic [N-1:0]    s_ready;
  logic            s_pv;
  logic [DW-1:0]   s_data;
  logic [PW-1:0]   s_pri;
  logic [1:0]      s_src;

  assign s_ready = sel_a ? ready_a : ready_m;
  assign s_pv    = sel_a ? pv_a    : pv_m;
  assign s_data  = sel_a ? pdata_a : pdata_m;
  assign s_pri   = sel_a ? ppri_a  : ppri_m;
  assign s_src   = sel_a ? psrc_a  : psrc_m;

  logic [DW-1:0] data_tab [N];
  logic [PW-1:0] pri_tab  [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chiplib_pri_queue_push_arb #(
    .NumReq(N), .DataWidth(DW), .PriorityWidth(PW), .AgeLimit(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(ready_m),
    .req_data(req_data), .req_pri(req_pri),
    .queue_push_valid(pv_m), .queue_push_data(pdata_m),
    .queue_push_pri(ppri_m), .queue_push_src(psrc_m),
    .full(full)
  );

  chiplib_pri_queue_push_arb #(
    .NumReq(N), .DataWidth(DW), .PriorityWidth(PW), .AgeLimit(2)
  ) dut_a (
    .clk(clk), .rst(rst_a),
    .req_valid(req_valid), .req_ready(ready_a),
    .req_data(req_data), .req_pri(req_pri),
    .queue_push_valid(pv_a), .queue_push_data(pdata_a),
    .queue_push_pri(ppri_a), .queue_push_src(psrc_a),
    .full(full)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [DW-1:0] d, input logic [PW-1:0] p);
    req_data[i*DW +: DW] = d;
    req_pri[i*PW +: PW]  = p;
    data_tab[i] = d;
    pri_tab[i]  = p;
  endtask

  function automatic vec_t mk(input logic [N-1:0] v, input logic f,
                              input logic [N-1:0] r, input logic pv, input int src);
    vec_t t;
    t.valid = v; t.full = f; t.exp_ready = r; t.exp_pv = pv; t.exp_src = src;
    return t;
  endfunction

  // Called shortly after a rising edge: apply inputs, check, advance one cycle
  task automatic run_vec(input vec_t v, input string tag);
    req_valid = v.valid;
    full      = v.full;
    #1;
    check({tag, "_ready"}, 64'(s_ready), 64'(v.exp_ready));
    check({tag, "_push_valid"}, 64'(s_pv), 64'(v.exp_pv));
    if (v.exp_pv) begin
      check({tag, "_push_src"},  64'(s_src),  64'(v.exp_src));
      check({tag, "_push_data"}, 64'(s_data), 64'(data_tab[v.exp_src]));
      check({tag, "_push_pri"},  64'(s_pri),  64'(pri_tab[v.exp_src]));
    end
    @(posedge clk); #1;
  endtask

  vec_t v_main [10];
  vec_t v_age  [7];
  ent_t sb [$];

  initial begin
    rst = 1'b1; rst_a = 1'b1; full = 1'b0; req_valid = '0;
    req_data = '0; req_pri = '0;
    for (int i = 0; i < N; i++) set_slot(i, 64'h100 + 64'(i), 16'd0);

    // Ties between 1 and 2 alternate; a 3-cycle full stall freezes the output
    v_main[0] = mk(4'b1111, 1'b0, 4'b0010, 1'b0, 0);
    v_main[1] = mk(4'b1111, 1'b0, 4'b0100, 1'b1, 1);
    v_main[2] = mk(4'b1111, 1'b0, 4'b0010, 1'b1, 2);
    v_main[3] = mk(4'b1111, 1'b0, 4'b0100, 1'b1, 1);
    v_main[4] = mk(4'b1111, 1'b1, 4'b0000, 1'b1, 2);
    v_main[5] = mk(4'b1111, 1'b1, 4'b0000, 1'b1, 2);
    v_main[6] = mk(4'b1111, 1'b1, 4'b0000, 1'b1, 2);
    v_main[7] = mk(4'b1111, 1'b0, 4'b0010, 1'b1, 2);
    v_main[8] = mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1);
    v_main[9] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 0);

    // AgeLimit=2: the starving requesters 3 then 0 win before 1/2 resume
    v_age[0] = mk(4'b1111, 1'b0, 4'b0010, 1'b0, 0);
    v_age[1] = mk(4'b1111, 1'b0, 4'b0100, 1'b1, 1);
    v_age[2] = mk(4'b1111, 1'b0, 4'b1000, 1'b1, 2);
    v_age[3] = mk(4'b1111, 1'b0, 4'b0001, 1'b1, 3);
    v_age[4] = mk(4'b1111, 1'b0, 4'b0010, 1'b1, 0);
    v_age[5] = mk(4'b1111, 1'b0, 4'b0100, 1'b1, 1);
    v_age[6] = mk(4'b0000, 1'b0, 4'b0000, 1'b1, 2);

    // Reset state, with a request present while rst is high
    repeat (2) @(posedge clk);
    #1;
    set_slot(0, 64'hA, 16'd5);
    req_valid = 4'b0001;
    #1;
    check("rst_ready", 64'(ready_m), 64'd0);
    check("rst_push_valid", 64'(pv_m), 64'd0);
    @(posedge clk); #1;

    // First transaction: accepted in cycle 0, visible in cycle 1
    rst = 1'b0;
    #1;
    check("first_ready", 64'(ready_m), 64'b0001);
    check("first_push_valid_c0", 64'(pv_m), 64'd0);
    @(posedge clk); #1;
    req_valid = '0;
    #1;
    check("first_push_valid", 64'(pv_m), 64'd1);
    check("first_push_data", pdata_m, 64'hA);
    check("first_push_pri", 64'(ppri_m), 64'd5);
    check("first_push_src", 64'(psrc_m), 64'd0);
    check("first_ready_idle", 64'(ready_m), 64'd0);
    @(posedge clk); #1;

    // Priority ties and back-pressure on the AgeLimit=8 instance
    set_slot(0, 64'h100, 16'd9);
    set_slot(1, 64'h101, 16'd3);
    set_slot(2, 64'h102, 16'd3);
    set_slot(3, 64'h103, 16'd7);
    for (int i = 0; i < 10; i++) run_vec(v_main[i], $sformatf("main%0d", i));

    // Aging on the AgeLimit=2 instance, starting from a fresh reset
    rst = 1'b1; rst_a = 1'b0; sel_a = 1'b1;
    for (int i = 0; i < 7; i++) run_vec(v_age[i], $sformatf("age%0d", i));

    // Reset taken while an entry is held by full: it is dropped, rr restarts at 0
    rst_a = 1'b1; sel_a = 1'b0; rst = 1'b0;
    for (int i = 0; i < N; i++) set_slot(i, 64'h100 + 64'(i), 16'd5);
    req_valid = 4'b0100; full = 1'b1;
    #1;
    check("mrst_grant_ready", 64'(ready_m), 64'b0100);
    @(posedge clk); #1;
    req_valid = 4'b0110;
    #1;
    check("mrst_held_valid", 64'(pv_m), 64'd1);
    check("mrst_held_src", 64'(psrc_m), 64'd2);
    check("mrst_held_ready", 64'(ready_m), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 4'b1111;
    #1;
    check("mrst_in_reset_ready", 64'(ready_m), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; full = 1'b0;
    #1;
    check("mrst_dropped", 64'(pv_m), 64'd0);
    check("mrst_restart_idx0", 64'(ready_m), 64'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    #1;
    check("mrst_after_src", 64'(psrc_m), 64'd0);
    check("mrst_after_valid", 64'(pv_m), 64'd1);
    @(posedge clk); #1;

    // Single active requester wins every cycle
    for (int i = 0; i < 3; i++) run_vec(mk(4'b1000, 1'b0, 4'b1000, i > 0, 3), $sformatf("single%0d", i));
    run_vec(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 3), "single_tail");

    // Randomized traffic against a reference arbiter and scoreboard
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      int       m_age [N];
      logic     m_ov;
      int       m_rr;
      for (int i = 0; i < N; i++) m_age[i] = 0;
      m_ov = 1'b0;
      m_rr = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        logic [N-1:0] starv;
        logic [N-1:0] cand;
        logic [N-1:0] exp_ready;
        logic [PW-1:0] minp;
        logic         can_load;
        int           win;
        for (int i = 0; i < N; i++) begin
          req_valid[i] = ($urandom_range(0, 9) < 8);
          if ($urandom_range(0, 1) == 0)
            set_slot(i, {$urandom, $urandom}, 16'($urandom_range(0, 3)));
        end
        full = ($urandom_range(0, 3) == 0);
        #1;
        minp = '1;
        starv = '0;
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && pri_tab[i] < minp) minp = pri_tab[i];
          starv[i] = req_valid[i] && (m_age[i] == 8);
        end
        for (int i = 0; i < N; i++)
          cand[i] = (starv != '0) ? starv[i] : (req_valid[i] && pri_tab[i] == minp);
        win = -1;
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_rr + k) % N;
          if (win < 0 && cand[j]) win = j;
        end
        can_load = !m_ov || !full;
        exp_ready = (win >= 0 && can_load) ? (4'b0001 << win) : 4'b0000;
        check("rnd_ready", 64'(ready_m), 64'(exp_ready));
        check("rnd_push_valid", 64'(pv_m), 64'(m_ov));
        if (pv_m && !full) begin
          if (sb.size() == 0) begin
            check("rnd_unexpected_push", 64'(sb.size()), 64'd1);
          end else begin
            ent_t e;
            e = sb.pop_front();
            check("rnd_push_data", pdata_m, e.data);
            check("rnd_push_pri", 64'(ppri_m), 64'(e.pri));
            check("rnd_push_src", 64'(psrc_m), 64'(e.src));
          end
        end
        if (exp_ready != '0) begin
          ent_t e;
          e.data = data_tab[win]; e.pri = pri_tab[win]; e.src = win;
          sb.push_back(e);
          m_ov = 1'b1;
          m_rr = (win + 1) % N;
          for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || i == win) m_age[i] = 0;
            else if (m_age[i] < 8) m_age[i] = m_age[i] + 1;
          end
        end else begin
          if (m_ov && !full) m_ov = 1'b0;
          for (int i = 0; i < N; i++) if (!req_valid[i]) m_age[i] = 0;
        end
        @(posedge clk); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
